// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: Decode fields and hazard input toward the control unit,
// pipelined control bundle and mul/div stall back to the datapath.
interface pipe_ctrl_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       flush_e;
    logic [2:0] ImmSrcD;
    logic       IllegalD;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic       MemWriteE;
    logic       BranchE;
    logic       JumpE;
    logic       JalrE;
    logic       LuiE;
    logic       ALUSrcE;
    logic [3:0] ALUControlE;
    logic [2:0] BranchTypeE;
    logic       RegWriteM;
    logic [1:0] ResultSrcM;
    logic       MemWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
    logic       md_busy;

    modport master (
        output op, funct3, funct7, flush_e,
        input  ImmSrcD, IllegalD,
        input  RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, JalrE, LuiE, ALUSrcE,
        input  ALUControlE, BranchTypeE,
        input  RegWriteM, ResultSrcM, MemWriteM,
        input  RegWriteW, ResultSrcW,
        input  md_busy
    );

    modport slave (
        input  op, funct3, funct7, flush_e,
        output ImmSrcD, IllegalD,
        output RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, JalrE, LuiE, ALUSrcE,
        output ALUControlE, BranchTypeE,
        output RegWriteM, ResultSrcM, MemWriteM,
        output RegWriteW, ResultSrcW,
        output md_busy
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I(+M) control unit: Decode-stage decoder, ID/EX, EX/MEM, MEM/WB
// control registers and a mul/div sequencer that holds Execute while busy.
module pipe_ctrl_unit #(
    parameter int MULDIV_EN  = 1,
    parameter int MD_LATENCY = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    pipe_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       lui;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [2:0] br_type;
    } ctrl_t;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    // Base-ISA ALU op; sub exists only for register-register add.
    function automatic logic [3:0] base_alu(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'b000:  base_alu = (is_reg && f7b5) ? 4'b0001 : 4'b0000;
            3'b001:  base_alu = 4'b0110;
            3'b010:  base_alu = 4'b0101;
            3'b011:  base_alu = 4'b1001;
            3'b100:  base_alu = 4'b0100;
            3'b101:  base_alu = f7b5 ? 4'b1000 : 4'b0111;
            3'b110:  base_alu = 4'b0011;
            default: base_alu = 4'b0010;
        endcase
    endfunction

    function automatic logic [3:0] md_alu(input logic [2:0] f3);
        case (f3)
            3'b000:                 md_alu = 4'b1010;
            3'b001, 3'b010, 3'b011: md_alu = 4'b1011;
            3'b100, 3'b101:         md_alu = 4'b1100;
            default:                md_alu = 4'b1101;
        endcase
    endfunction

    ctrl_t      w_dec;
    logic [2:0] w_imm_src;
    logic       w_illegal;
    logic       w_muldiv_e;
    logic       w_md_busy;

    ctrl_t      r_de;
    logic [3:0] r_em;
    logic [2:0] r_mw;
    state_t     r_state;
    logic [3:0] r_cnt;

    always_comb begin
        w_dec     = '0;
        w_imm_src = 3'b000;
        w_illegal = 1'b0;
        case (bus.op)
            OP_LW: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b01;
                w_dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                w_imm_src       = 3'b001;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_R: begin
                if (bus.funct7 == 7'b0000001) begin
                    if (MULDIV_EN != 0) begin
                        w_dec.reg_write = 1'b1;
                        w_dec.alu_ctrl  = md_alu(bus.funct3);
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_ctrl  = base_alu(bus.funct3, bus.funct7[5], 1'b1);
                end
            end
            OP_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = base_alu(bus.funct3, bus.funct7[5], 1'b0);
            end
            OP_BR: begin
                w_imm_src      = 3'b010;
                w_dec.branch   = 1'b1;
                w_dec.alu_ctrl = 4'b0001;
                w_dec.br_type  = bus.funct3;
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.result_src = 2'b10;
            end
            OP_JAL: begin
                w_imm_src        = 3'b011;
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.result_src = 2'b10;
            end
            OP_LUI: begin
                w_imm_src       = 3'b100;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.lui       = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Busy drops in the last Execute cycle so the op leaves on that edge.
    assign w_muldiv_e = (r_de.alu_ctrl[3:1] == 3'b101) || (r_de.alu_ctrl[3:1] == 3'b110);
    assign w_md_busy  = w_muldiv_e && !(r_state == ST_BUSY && r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_de    <= '0;
            r_em    <= '0;
            r_mw    <= '0;
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            if (!w_md_busy) r_de <= bus.flush_e ? '0 : w_dec;
            r_em <= w_md_busy ? 4'b0000 : {r_de.reg_write, r_de.result_src, r_de.mem_write};
            r_mw <= r_em[3:1];
            case (r_state)
                ST_IDLE: begin
                    if (w_muldiv_e) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= MD_INIT;
                    end
                end
                default: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    else               r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ImmSrcD     = w_imm_src;
    assign bus.IllegalD    = w_illegal;
    assign bus.RegWriteE   = r_de.reg_write;
    assign bus.ResultSrcE  = r_de.result_src;
    assign bus.MemWriteE   = r_de.mem_write;
    assign bus.BranchE     = r_de.branch;
    assign bus.JumpE       = r_de.jump;
    assign bus.JalrE       = r_de.jalr;
    assign bus.LuiE        = r_de.lui;
    assign bus.ALUSrcE     = r_de.alu_src;
    assign bus.ALUControlE = r_de.alu_ctrl;
    assign bus.BranchTypeE = r_de.br_type;
    assign bus.RegWriteM   = r_em[3];
    assign bus.ResultSrcM  = r_em[2:1];
    assign bus.MemWriteM   = r_em[0];
    assign bus.RegWriteW   = r_mw[2];
    assign bus.ResultSrcW  = r_mw[1:0];
    assign bus.md_busy     = w_md_busy;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode fields, stage latency, flush,
// mul/div hold/bubble timing, illegal ops and reset behaviour.
module tb_pipe_ctrl_unit;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    pipe_ctrl_unit_if u_if ();
    pipe_ctrl_unit_if u_if0 ();

    pipe_ctrl_unit #(.MULDIV_EN(1), .MD_LATENCY(4)) dut (.clk(clk), .reset_n(reset_n), .bus(u_if.slave));
    pipe_ctrl_unit #(.MULDIV_EN(0), .MD_LATENCY(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(u_if0.slave));

    assign u_if0.op      = u_if.op;
    assign u_if0.funct3  = u_if.funct3;
    assign u_if0.funct7  = u_if.funct7;
    assign u_if0.flush_e = u_if.flush_e;

    wire [15:0] e_all = {u_if.RegWriteE, u_if.ResultSrcE, u_if.MemWriteE, u_if.BranchE, u_if.JumpE,
                         u_if.JalrE, u_if.LuiE, u_if.ALUSrcE, u_if.ALUControlE, u_if.BranchTypeE};
    wire [3:0]  m_all = {u_if.RegWriteM, u_if.ResultSrcM, u_if.MemWriteM};
    wire [2:0]  w_all = {u_if.RegWriteW, u_if.ResultSrcW};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        u_if.op     = op;
        u_if.funct3 = f3;
        u_if.funct7 = f7;
    endtask

    task automatic set_nop();
        set_d(7'b0000000, 3'b000, 7'b0000000);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        u_if.flush_e = 1'b0;
        set_nop();
        tick();
        tick();
        checks++; if (e_all !== 16'h0) begin failures++; $display("FAIL rst_e got=%0h exp=0", e_all); end
        checks++; if (m_all !== 4'h0) begin failures++; $display("FAIL rst_m got=%0h exp=0", m_all); end
        checks++; if (w_all !== 3'h0) begin failures++; $display("FAIL rst_w got=%0h exp=0", w_all); end
        checks++; if (u_if.md_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", u_if.md_busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        set_d(7'b0000011, 3'b010, 7'b0000000);
        #1;
        checks++; if (u_if.ImmSrcD !== 3'b000) begin failures++; $display("FAIL lw_imm got=%0h exp=0", u_if.ImmSrcD); end
        checks++; if (u_if.IllegalD !== 1'b0) begin failures++; $display("FAIL lw_illegal got=%0b exp=0", u_if.IllegalD); end
        tick();
        set_nop();
        checks++; if (e_all !== 16'b1_01_0_0_0_0_0_1_0000_000) begin failures++; $display("FAIL lw_e got=%0h exp=%0h", e_all, 16'b1_01_0_0_0_0_0_1_0000_000); end
        tick();
        checks++; if (m_all !== 4'b1010) begin failures++; $display("FAIL lw_m got=%0h exp=a", m_all); end
        tick();
        checks++; if (w_all !== 3'b101) begin failures++; $display("FAIL lw_w got=%0h exp=5", w_all); end
    endtask

    task automatic test_decode();
        // sub
        set_d(7'b0110011, 3'b000, 7'b0100000); tick();
        checks++; if (u_if.ALUControlE !== 4'b0001 || u_if.RegWriteE !== 1'b1 || u_if.ALUSrcE !== 1'b0) begin failures++; $display("FAIL sub got=%0h exp=1", u_if.ALUControlE); end
        // beq
        set_d(7'b1100011, 3'b000, 7'b0000000); #1;
        checks++; if (u_if.ImmSrcD !== 3'b010) begin failures++; $display("FAIL beq_imm got=%0h exp=2", u_if.ImmSrcD); end
        tick();
        checks++; if (u_if.BranchE !== 1'b1 || u_if.BranchTypeE !== 3'b000 || u_if.ALUControlE !== 4'b0001 || u_if.RegWriteE !== 1'b0) begin failures++; $display("FAIL beq_e got=%0h exp=%0h", e_all, 16'b0_00_0_1_0_0_0_0_0001_000); end
        // bne
        set_d(7'b1100011, 3'b001, 7'b0000000); tick();
        checks++; if (u_if.BranchTypeE !== 3'b001) begin failures++; $display("FAIL bne_type got=%0h exp=1", u_if.BranchTypeE); end
        // sra / srai / addi with funct7[5] set
        set_d(7'b0110011, 3'b101, 7'b0100000); tick();
        checks++; if (u_if.ALUControlE !== 4'b1000) begin failures++; $display("FAIL sra got=%0h exp=8", u_if.ALUControlE); end
        set_d(7'b0010011, 3'b101, 7'b0100000); tick();
        checks++; if (u_if.ALUControlE !== 4'b1000 || u_if.ALUSrcE !== 1'b1) begin failures++; $display("FAIL srai got=%0h exp=8", u_if.ALUControlE); end
        set_d(7'b0010011, 3'b000, 7'b0100000); tick();
        checks++; if (u_if.ALUControlE !== 4'b0000) begin failures++; $display("FAIL addi got=%0h exp=0", u_if.ALUControlE); end
        // sw
        set_d(7'b0100011, 3'b010, 7'b0000000); #1;
        checks++; if (u_if.ImmSrcD !== 3'b001) begin failures++; $display("FAIL sw_imm got=%0h exp=1", u_if.ImmSrcD); end
        tick();
        checks++; if (u_if.MemWriteE !== 1'b1 || u_if.RegWriteE !== 1'b0) begin failures++; $display("FAIL sw_e got=%0h exp=%0h", e_all, 16'b0_00_1_0_0_0_0_1_0000_000); end
        // jal
        set_d(7'b1101111, 3'b000, 7'b0000000); #1;
        checks++; if (u_if.ImmSrcD !== 3'b011) begin failures++; $display("FAIL jal_imm got=%0h exp=3", u_if.ImmSrcD); end
        tick();
        checks++; if (u_if.JumpE !== 1'b1 || u_if.ResultSrcE !== 2'b10) begin failures++; $display("FAIL jal_e got=%0h exp=%0h", e_all, 16'b1_10_0_0_1_0_0_0_0000_000); end
        // lui
        set_d(7'b0110111, 3'b000, 7'b0000000); #1;
        checks++; if (u_if.ImmSrcD !== 3'b100) begin failures++; $display("FAIL lui_imm got=%0h exp=4", u_if.ImmSrcD); end
        tick();
        checks++; if (u_if.LuiE !== 1'b1 || u_if.RegWriteE !== 1'b1) begin failures++; $display("FAIL lui_e got=%0h exp=%0h", e_all, 16'b1_00_0_0_0_0_1_1_0000_000); end
        set_nop(); tick(); tick();
    endtask

    task automatic test_mul();
        logic [3:0] exp_busy;
        exp_busy = 4'b0111;
        set_d(7'b0110011, 3'b000, 7'b0000001); #1;
        checks++; if (u_if.IllegalD !== 1'b0) begin failures++; $display("FAIL mul_illegal got=%0b exp=0", u_if.IllegalD); end
        checks++; if (u_if0.IllegalD !== 1'b1) begin failures++; $display("FAIL nomd_illegal got=%0b exp=1", u_if0.IllegalD); end
        tick();
        checks++; if (u_if.ALUControlE !== 4'b1010 || u_if.RegWriteE !== 1'b1) begin failures++; $display("FAIL mul_e got=%0h exp=a", u_if.ALUControlE); end
        checks++; if (u_if0.RegWriteE !== 1'b0) begin failures++; $display("FAIL nomd_regwrite got=%0b exp=0", u_if0.RegWriteE); end
        set_d(7'b0110011, 3'b000, 7'b0000000);
        for (int i = 0; i < 4; i++) begin
            checks++; if (u_if.md_busy !== exp_busy[i]) begin failures++; $display("FAIL mul_busy%0d got=%0b exp=%0b", i, u_if.md_busy, exp_busy[i]); end
            checks++; if (u_if.ALUControlE !== 4'b1010 || u_if.RegWriteM !== 1'b0) begin failures++; $display("FAIL mul_hold%0d got=%0h/%0b exp=a/0", i, u_if.ALUControlE, u_if.RegWriteM); end
            if (i < 3) tick();
        end
        tick();
        checks++; if (u_if.RegWriteM !== 1'b1 || u_if.ALUControlE !== 4'b0000 || u_if.RegWriteE !== 1'b1 || u_if.md_busy !== 1'b0) begin failures++; $display("FAIL mul_release got=%0h/%0b exp=0/1", u_if.ALUControlE, u_if.RegWriteM); end
        set_nop(); tick(); tick();
    endtask

    task automatic test_flush();
        int n;
        set_d(7'b0110011, 3'b000, 7'b0000000);
        u_if.flush_e = 1'b1;
        tick();
        checks++; if (e_all !== 16'h0) begin failures++; $display("FAIL flush_e got=%0h exp=0", e_all); end
        u_if.flush_e = 1'b0;
        tick();
        checks++; if (u_if.RegWriteE !== 1'b1) begin failures++; $display("FAIL flush_after got=%0b exp=1", u_if.RegWriteE); end
        set_d(7'b0110011, 3'b000, 7'b0000001);
        tick();
        set_d(7'b0110011, 3'b000, 7'b0000000);
        u_if.flush_e = 1'b1;
        tick();
        checks++; if (u_if.ALUControlE !== 4'b1010 || u_if.RegWriteE !== 1'b1 || u_if.md_busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%0h exp=a", u_if.ALUControlE); end
        u_if.flush_e = 1'b0;
        n = 0;
        while (u_if.md_busy === 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (u_if.md_busy !== 1'b0) begin failures++; $display("FAIL flush_timeout got=%0b exp=0", u_if.md_busy); end
        set_nop(); tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int nb;
        set_d(7'b0110011, 3'b000, 7'b0000001); tick();
        set_d(7'b0110011, 3'b100, 7'b0000001);
        tick(); tick(); tick(); tick();
        checks++; if (u_if.ALUControlE !== 4'b1100 || u_if.md_busy !== 1'b1 || u_if.RegWriteM !== 1'b1) begin failures++; $display("FAIL b2b_enter got=%0h/%0b exp=c/1", u_if.ALUControlE, u_if.md_busy); end
        set_nop();
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (u_if.md_busy === 1'b1) nb++;
            tick();
        end
        checks++; if (nb !== 3) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=3", nb); end
        checks++; if (u_if.ALUControlE !== 4'b0000 || u_if.RegWriteM !== 1'b1) begin failures++; $display("FAIL b2b_release got=%0h/%0b exp=0/1", u_if.ALUControlE, u_if.RegWriteM); end
        tick(); tick();
    endtask

    task automatic test_illegal();
        set_d(7'b1111111, 3'b000, 7'b0000000); #1;
        checks++; if (u_if.IllegalD !== 1'b1 || u_if.ImmSrcD !== 3'b000) begin failures++; $display("FAIL ill_d got=%0b exp=1", u_if.IllegalD); end
        tick();
        checks++; if (e_all !== 16'h0) begin failures++; $display("FAIL ill_e got=%0h exp=0", e_all); end
        set_nop(); tick();
    endtask

    task automatic test_reset_mid();
        set_d(7'b0000011, 3'b010, 7'b0000000);
        tick(); tick();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (e_all !== 16'h0 || m_all !== 4'h0 || w_all !== 3'h0) begin failures++; $display("FAIL rstmid got=%0h/%0h/%0h exp=0/0/0", e_all, m_all, w_all); end
        checks++; if (u_if.md_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", u_if.md_busy); end
        reset_n = 1'b1;
        set_nop(); tick();
    endtask

    task automatic test_reset_busy();
        int nb;
        set_d(7'b0110011, 3'b000, 7'b0000001);
        tick(); tick();
        checks++; if (u_if.md_busy !== 1'b1) begin failures++; $display("FAIL rstb_pre got=%0b exp=1", u_if.md_busy); end
        reset_n = 1'b0;
        tick();
        checks++; if (u_if.md_busy !== 1'b0 || e_all !== 16'h0) begin failures++; $display("FAIL rstb got=%0b/%0h exp=0/0", u_if.md_busy, e_all); end
        reset_n = 1'b1;
        tick();
        set_nop();
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (u_if.md_busy === 1'b1) nb++;
            tick();
        end
        checks++; if (nb !== 3) begin failures++; $display("FAIL rstb_restart got=%0d exp=3", nb); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lw();
        test_decode();
        test_mul();
        test_flush();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
